sync_frame_fifo: RTL

Single-clock, parametrised frame FIFO for Ethernet frames: the next generation of the team's dual-clock frame FIFO for designs where MAC and consumer share one clock. Stores a DW-bit data word plus a 1-bit end-of-frame delimiter per entry. Adds frame-level commit/abort: the reader only ever sees complete, committed frames, so a partial or bad frame (CRC error, overflow) is rolled back. Exposes a committed-frame count so schedulers can start a read only when a whole frame is present.

---
 rtl/frame_fifo_pkg.sv | 10 +
 rtl/sdp_ram_1clk.sv | 21 ++
 rtl/sync_frame_fifo.sv | 114 +++++++++++
 3 files changed

// File: rtl/frame_fifo_pkg.sv
// frame_fifo_pkg: write-state encodings and default sizing shared by the frame FIFOs
package frame_fifo_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, DROP} wr_state_t;
  localparam int ETH_MTU = 1514;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 13;
  localparam int DEF_AFULL_CNT = 6660;
  localparam int DEF_AEMPTY_CNT = ETH_MTU;
  localparam int DEF_HALF_CNT = 4096;
endpackage

// File: rtl/sdp_ram_1clk.sv
// sdp_ram_1clk: simple dual-port RAM, one write and one registered read port
module sdp_ram_1clk #(
  parameter int AW = 13,
  parameter int W = 9
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/sync_frame_fifo.sv
// sync_frame_fifo: single-clock frame FIFO with commit/abort; frame_cnt drops once the EOD word is on EOD_out.
// Optional SYNC_FRAME_FIFO_CUT_THROUGH_EN: reads follow the speculative pointer and add the rd_err output.
module sync_frame_fifo
  import frame_fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int AFULL_CNT = DEF_AFULL_CNT,
  parameter int AEMPTY_CNT = DEF_AEMPTY_CNT,
  parameter int HALF_CNT = DEF_HALF_CNT
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [DW-1:0] di,
  input  logic          we,
  input  logic          EOD_in,
  input  logic          abort,
  output logic [DW-1:0] dout,
  output logic          EOD_out,
  input  logic          re,
  output logic          empty_flag,
  output logic          aempty_flag,
  output logic          full_flag,
  output logic          afull_flag,
  output logic          half_flag,
  output logic [AW:0]   frame_cnt,
  output logic          frame_avail,
  output logic          ovf_drop
`ifdef SYNC_FRAME_FIFO_CUT_THROUGH_EN
  ,
  output logic          rd_err
`endif
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;
  wr_state_t state, state_n;
  logic [AW:0] wadr, wadr_cmt, radr, wadr_n, wadr_cmt_n, radr_adv, radr_n, spec_occ, cmt_occ;
  logic [DW:0] ram_q;
  logic wr_ok, commit, rd_ok, ovf, roll, rd_q, empty_n;
  assign wr_ok = we & ~full_flag & (state != DROP) & ~abort;
  assign commit = wr_ok & EOD_in;
  assign rd_ok = re & ~empty_flag;
  assign ovf = we & full_flag & (state != DROP) & ~abort;
  assign roll = abort | ovf;
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else if (ovf) state_n = EOD_in ? IDLE : DROP;
    else if (state == DROP) state_n = (we & EOD_in) ? IDLE : DROP;
    else if (wr_ok) state_n = EOD_in ? IDLE : FRAME;
  end
  assign wadr_n = roll ? wadr_cmt : wadr + (AW+1)'(wr_ok);
  assign wadr_cmt_n = commit ? wadr + 1 : wadr_cmt;
  assign radr_adv = radr + (AW+1)'(rd_ok);
`ifdef SYNC_FRAME_FIFO_CUT_THROUGH_EN
  logic [AW:0] rd_into;
  logic rd_err_n;
  // reader is inside the frame being rolled back: pull it back to the commit point
  assign rd_into = radr_adv - wadr_cmt;
  assign rd_err_n = roll & (rd_into != '0) & (rd_into <= wadr - wadr_cmt);
  assign radr_n = rd_err_n ? wadr_cmt : radr_adv;
  assign empty_n = radr_n == wadr_n;
`else
  assign radr_n = radr_adv;
  assign empty_n = radr_n == wadr_cmt_n;
`endif
  assign spec_occ = wadr_n - radr_n;
  assign cmt_occ = wadr_cmt_n - radr_n;
  assign {EOD_out, dout} = ram_q;
  assign frame_avail = frame_cnt != '0;
  sdp_ram_1clk #(.AW(AW), .W(DW+1)) u_ram (
    .clk(clk),
    .arst_n(arst_n),
    .we(wr_ok),
    .wa(wadr[AW-1:0]),
    .wd({EOD_in, di}),
    .re(rd_ok),
    .ra(radr[AW-1:0]),
    .rd(ram_q)
  );
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= IDLE;
      wadr <= '0;
      wadr_cmt <= '0;
      radr <= '0;
      rd_q <= 1'b0;
      frame_cnt <= '0;
      ovf_drop <= 1'b0;
      empty_flag <= 1'b1;
      aempty_flag <= 1'b1;
      full_flag <= 1'b0;
      afull_flag <= 1'b0;
      half_flag <= 1'b0;
`ifdef SYNC_FRAME_FIFO_CUT_THROUGH_EN
      rd_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      wadr <= wadr_n;
      wadr_cmt <= wadr_cmt_n;
      radr <= radr_n;
      rd_q <= rd_ok;
      frame_cnt <= frame_cnt + (AW+1)'(commit) - (AW+1)'(rd_q & EOD_out);
      ovf_drop <= ovf;
      empty_flag <= empty_n;
      aempty_flag <= cmt_occ <= (AW+1)'(AEMPTY_CNT);
      full_flag <= spec_occ == DEPTH;
      afull_flag <= spec_occ >= (AW+1)'(AFULL_CNT);
      half_flag <= spec_occ >= (AW+1)'(HALF_CNT);
`ifdef SYNC_FRAME_FIFO_CUT_THROUGH_EN
      rd_err <= rd_err_n;
`endif
    end
endmodule
